// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU control sequencer: opcodes, instruction
// field positions, sequencer states and ALU operation codes.
package cpu_pkg;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_JMP   = 4'h5;
    localparam logic [3:0] OP_JZ    = 4'h6;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam int unsigned OPC_LSB  = 12;
    localparam int unsigned OPC_W    = 4;
    localparam int unsigned REG_LSB  = 10;
    localparam int unsigned REG_W    = 2;
    localparam int unsigned ADDR_LSB = 0;

    localparam int unsigned CNT_W = 8;

    typedef enum logic [2:0] {
        S_FETCH,
        S_FWAIT,
        S_DECODE,
        S_MRD,
        S_MWAIT,
        S_WB,
        S_MWR,
        S_HALT
    } state_e;

    typedef enum logic [1:0] {
        ALU_PASS = 2'b00,
        ALU_ADD  = 2'b01,
        ALU_SUB  = 2'b10
    } alu_op_e;

    function automatic logic is_mem_read(input logic [3:0] op);
        return (op == OP_LOAD) || (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/cpu_latency_cnt.sv
// Down-counter for ROM/RAM wait states; done is high while the count is zero,
// i.e. in the last wait cycle.
module cpu_latency_cnt
    import cpu_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/cpu_ctrl_seq.sv
// Multi-cycle control sequencer: fetches from ROM, decodes, sequences RAM
// reads/writes and issues register-file and ALU controls to the datapath.
module cpu_ctrl_seq
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W  = 6,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ROM_LAT = 1,
    parameter int unsigned RAM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_from_rom,
    input  logic              alu_zero,
    output logic [ADDR_W-1:0] address_to_rom,
    output logic              enable_to_rom,
    output logic [ADDR_W-1:0] address_to_ram,
    output logic              read_enable_to_ram,
    output logic              write_enable_to_ram,
    output logic              enable_ram_read,
    output logic              bus_drive_en,
    output logic [DATA_W-1:0] ir,
    output logic [1:0]        reg_sel,
    output logic              reg_we,
    output logic              wb_sel_alu,
    output logic [1:0]        alu_op,
    output logic              halted,
    output logic              illegal_op
);

    localparam logic [CNT_W-1:0] ROM_WAIT = CNT_W'(ROM_LAT - 1);
    localparam logic [CNT_W-1:0] RAM_WAIT = CNT_W'(RAM_LAT - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic              illegal_q, illegal_d;
    logic              halted_q, halted_d;
    logic              wb_sel_q, wb_sel_d;
    alu_op_e           alu_op_q, alu_op_d;

    logic [OPC_W-1:0]  opcode;
    logic [ADDR_W-1:0] ir_addr;
    logic [ADDR_W-1:0] pc_inc;
    logic              cnt_load;
    logic              cnt_done;

    assign opcode  = ir_q[OPC_LSB +: OPC_W];
    assign ir_addr = ir_q[ADDR_LSB +: ADDR_W];
    assign pc_inc  = pc_q + ADDR_W'(1);

    // One counter serves both wait phases: armed in FETCH for the ROM, in MRD for the RAM.
    assign cnt_load = (state_q == S_FETCH) || (state_q == S_MRD);

    cpu_latency_cnt u_lat_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val ((state_q == S_FETCH) ? ROM_WAIT : RAM_WAIT),
        .done     (cnt_done)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        illegal_d = illegal_q;
        halted_d  = halted_q;
        wb_sel_d  = wb_sel_q;
        alu_op_d  = alu_op_q;
        case (state_q)
            S_FETCH: state_d = S_FWAIT;
            S_FWAIT: begin
                if (cnt_done) begin
                    ir_d    = data_from_rom;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                pc_d    = pc_inc;
                state_d = S_FETCH;
                case (opcode)
                    OP_NOP:   ;
                    OP_LOAD, OP_ADD, OP_SUB: state_d = S_MRD;
                    OP_STORE: state_d = S_MWR;
                    OP_JMP:   pc_d = ir_addr;
                    OP_JZ:    if (alu_zero) pc_d = ir_addr;
                    OP_HALT: begin
                        state_d  = S_HALT;
                        halted_d = 1'b1;
                    end
                    default:  illegal_d = 1'b1;
                endcase
            end
            S_MRD:   state_d = S_MWAIT;
            S_MWAIT: begin
                if (cnt_done) begin
                    state_d = S_WB;
                    case (opcode)
                        OP_ADD: begin
                            wb_sel_d = 1'b1;
                            alu_op_d = ALU_ADD;
                        end
                        OP_SUB: begin
                            wb_sel_d = 1'b1;
                            alu_op_d = ALU_SUB;
                        end
                        default: begin
                            wb_sel_d = 1'b0;
                            alu_op_d = ALU_PASS;
                        end
                    endcase
                end
            end
            S_WB, S_MWR: state_d = S_FETCH;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            pc_q      <= '0;
            ir_q      <= '0;
            illegal_q <= 1'b0;
            halted_q  <= 1'b0;
            wb_sel_q  <= 1'b0;
            alu_op_q  <= ALU_PASS;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            illegal_q <= illegal_d;
            halted_q  <= halted_d;
            wb_sel_q  <= wb_sel_d;
            alu_op_q  <= alu_op_d;
        end
    end

    // Strobes decode the registered state; reset holds every strobe low.
    assign enable_to_rom       = !reset && (state_q == S_FETCH);
    assign read_enable_to_ram  = !reset && (state_q == S_MRD);
    assign enable_ram_read     = !reset && (state_q == S_MWAIT) && cnt_done;
    assign write_enable_to_ram = !reset && (state_q == S_MWR);
    assign bus_drive_en        = !reset && (state_q == S_MWR);
    assign reg_we              = !reset && (state_q == S_WB);

    always_comb begin
        case (state_q)
            S_DECODE, S_MRD, S_MWAIT, S_WB, S_MWR: address_to_ram = ir_addr;
            default:                               address_to_ram = '0;
        endcase
    end

    assign address_to_rom = pc_q;
    assign ir             = ir_q;
    assign reg_sel        = ir_q[REG_LSB +: REG_W];
    assign wb_sel_alu     = wb_sel_q;
    assign alu_op         = alu_op_q;
    assign halted         = halted_q;
    assign illegal_op     = illegal_q;

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// Directed bench for cpu_ctrl_seq: cycle-by-cycle expected traces plus
// hand-written reset-abort and long-latency sequences.
module tb_cpu_ctrl_seq;

    typedef struct packed {
        logic       az;
        logic       care;
        logic [5:0] ram_a;
        logic       en;
        logic [5:0] rom_a;
        logic       rd;
        logic       wr;
        logic       bus;
        logic       cap;
        logic       we;
        logic [1:0] rsel;
        logic       wb;
        logic [1:0] op;
        logic       hlt;
        logic       ill;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic alu_zero = 1'b0;

    logic [15:0] rom [64];
    logic [15:0] p1;
    logic [15:0] p2 [3];

    logic [5:0]  a1, ra1, a2, ra2;
    logic        en1, rd1, wr1, cap1, bus1, we1, wb1, hlt1, ill1;
    logic        en2, rd2, wr2, cap2, bus2, we2, wb2, hlt2, ill2;
    logic [15:0] ir1, ir2;
    logic [1:0]  rsel1, op1, rsel2, op2;

    int n_checks = 0;
    int n_fail = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    cpu_ctrl_seq #(.ADDR_W(6), .DATA_W(16), .ROM_LAT(1), .RAM_LAT(1)) dut (
        .clk(clk), .reset(reset), .data_from_rom(p1), .alu_zero(alu_zero),
        .address_to_rom(a1), .enable_to_rom(en1), .address_to_ram(ra1),
        .read_enable_to_ram(rd1), .write_enable_to_ram(wr1), .enable_ram_read(cap1),
        .bus_drive_en(bus1), .ir(ir1), .reg_sel(rsel1), .reg_we(we1),
        .wb_sel_alu(wb1), .alu_op(op1), .halted(hlt1), .illegal_op(ill1)
    );

    cpu_ctrl_seq #(.ADDR_W(6), .DATA_W(16), .ROM_LAT(3), .RAM_LAT(2)) dut_slow (
        .clk(clk), .reset(reset), .data_from_rom(p2[2]), .alu_zero(alu_zero),
        .address_to_rom(a2), .enable_to_rom(en2), .address_to_ram(ra2),
        .read_enable_to_ram(rd2), .write_enable_to_ram(wr2), .enable_ram_read(cap2),
        .bus_drive_en(bus2), .ir(ir2), .reg_sel(rsel2), .reg_we(we2),
        .wb_sel_alu(wb2), .alu_op(op2), .halted(hlt2), .illegal_op(ill2)
    );

    // ROM models: data is valid only exactly ROM_LAT edges after the strobe.
    always @(posedge clk) begin
        p1    <= en1 ? rom[a1] : 16'hDEAD;
        p2[0] <= en2 ? rom[a2] : 16'hDEAD;
        p2[1] <= p2[0];
        p2[2] <= p2[1];
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 64; i++) rom[i] = 16'h0000;
    endtask

    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset(input string name);
        reset = 1'b1;
        alu_zero = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check({name, "_fast"}, {en1, rd1, wr1, cap1, bus1, we1, hlt1, ill1, wb1, op1, a1, ir1}, '0);
        check({name, "_slow"}, {en2, rd2, wr2, cap2, bus2, we2, hlt2, ill2, wb2, op2, a2, ir2}, '0);
        reset = 1'b0;
        #1;
    endtask

    function automatic vec_t v_fetch(input logic [5:0] pc, input logic ill);
        vec_t v = '0;
        v.en = 1'b1; v.rom_a = pc; v.care = 1'b1; v.ill = ill;
        return v;
    endfunction

    function automatic vec_t v_fwait(input logic [5:0] pc, input logic ill);
        vec_t v = '0;
        v.rom_a = pc; v.ill = ill;
        return v;
    endfunction

    function automatic vec_t v_dec(input logic [5:0] pc, input logic [5:0] ra,
                                   input logic ill, input logic az);
        vec_t v = '0;
        v.rom_a = pc; v.care = 1'b1; v.ram_a = ra; v.ill = ill; v.az = az;
        return v;
    endfunction

    function automatic vec_t v_halt(input logic [5:0] pc, input logic ill);
        vec_t v = '0;
        v.rom_a = pc; v.hlt = 1'b1; v.ill = ill;
        return v;
    endfunction

    task automatic add_short(input logic [5:0] pc, input logic [5:0] ra, input logic ill, input logic az);
        tbl.push_back(v_fetch(pc, ill));
        tbl.push_back(v_fwait(pc, ill));
        tbl.push_back(v_dec(pc, ra, ill, az));
    endtask

    task automatic add_rmw(input logic [5:0] pc, input logic [5:0] ra, input logic [1:0] rsel,
                           input logic wb, input logic [1:0] op);
        vec_t v;
        add_short(pc, ra, 1'b0, 1'b0);
        v = v_dec(pc + 6'd1, ra, 1'b0, 1'b0); v.rd = 1'b1;  tbl.push_back(v);
        v = v_dec(pc + 6'd1, ra, 1'b0, 1'b0); v.cap = 1'b1; tbl.push_back(v);
        v = v_dec(pc + 6'd1, ra, 1'b0, 1'b0);
        v.we = 1'b1; v.rsel = rsel; v.wb = wb; v.op = op;
        tbl.push_back(v);
    endtask

    task automatic add_store(input logic [5:0] pc, input logic [5:0] ra);
        vec_t v;
        add_short(pc, ra, 1'b0, 1'b0);
        v = v_dec(pc + 6'd1, ra, 1'b0, 1'b0); v.wr = 1'b1; v.bus = 1'b1;
        tbl.push_back(v);
    endtask

    task automatic run_table(input string name);
        vec_t a, e;
        for (int i = 0; i < tbl.size(); i++) begin
            e = tbl[i];
            alu_zero = e.az;
            a = '0;
            a.ram_a = ra1; a.en = en1; a.rom_a = a1; a.rd = rd1; a.wr = wr1; a.bus = bus1;
            a.cap = cap1; a.we = we1; a.rsel = rsel1; a.wb = wb1; a.op = op1;
            a.hlt = hlt1; a.ill = ill1;
            e.az = 1'b0;
            e.care = 1'b0;
            if (!tbl[i].care) begin
                a.ram_a = '0; e.ram_a = '0;
            end
            if (!tbl[i].we) begin
                a.rsel = '0; a.wb = 1'b0; a.op = '0;
                e.rsel = '0; e.wb = 1'b0; e.op = '0;
            end
            check($sformatf("%s[%0d]", name, i), 64'(a), 64'(e));
            next_cycle();
        end
        alu_zero = 1'b0;
        tbl.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rd_c, cap_c, cap_n, we_c, f_c;
        logic bus_seen;
        logic [5:0] ra_at_rd;
        logic [4:0] wb_ctl;

        // Straight-line program exercising every legal class, JZ both ways and PC wrap.
        clear_rom();
        rom[0]  = 16'h0000; rom[1]  = 16'h0000; rom[2]  = 16'h1805; rom[3]  = 16'h243F;
        rom[4]  = 16'h3C07; rom[5]  = 16'h4008; rom[6]  = 16'h6010; rom[16] = 16'h6020;
        rom[17] = 16'h7000; rom[18] = 16'h503F; rom[63] = 16'h0000;
        do_reset("reset_a");
        add_short(6'd0, 6'd0, 1'b0, 1'b0);
        add_short(6'd1, 6'd0, 1'b0, 1'b0);
        add_rmw(6'd2, 6'd5, 2'd2, 1'b0, 2'b00);
        add_store(6'd3, 6'd63);
        add_rmw(6'd4, 6'd7, 2'd3, 1'b1, 2'b01);
        add_rmw(6'd5, 6'd8, 2'd0, 1'b1, 2'b10);
        add_short(6'd6, 6'd16, 1'b0, 1'b1);
        add_short(6'd16, 6'd32, 1'b0, 1'b0);
        add_short(6'd17, 6'd0, 1'b0, 1'b0);
        add_short(6'd18, 6'd63, 1'b1, 1'b0);
        add_short(6'd63, 6'd0, 1'b1, 1'b0);
        tbl.push_back(v_fetch(6'd0, 1'b1));
        run_table("prog");

        // JMP to 63, then JMP 0x00 from PC 63.
        clear_rom();
        rom[0] = 16'h503F; rom[63] = 16'h5000;
        do_reset("reset_b");
        add_short(6'd0, 6'd63, 1'b0, 1'b0);
        add_short(6'd63, 6'd0, 1'b0, 1'b0);
        tbl.push_back(v_fetch(6'd0, 1'b0));
        run_table("jmp");

        // Illegal opcode then HALT: sticky flag, no strobes while halted.
        clear_rom();
        rom[0] = 16'h7000; rom[1] = 16'hF000;
        do_reset("reset_c");
        add_short(6'd0, 6'd0, 1'b0, 1'b0);
        add_short(6'd1, 6'd0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) tbl.push_back(v_halt(6'd2, 1'b1));
        run_table("halt");
        check("halt_ir", 64'(ir1), 64'(16'hF000));
        do_reset("reset_after_halt");

        // Reset while the STORE is in MWR.
        clear_rom();
        rom[0] = 16'h243F;
        do_reset("reset_d");
        add_short(6'd0, 6'd63, 1'b0, 1'b0);
        run_table("store");
        check("mwr_strobe", 64'({wr1, bus1, rd1, cap1, en1, ra1}), 64'({1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd63}));
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        next_cycle();
        check("abort_fetch", 64'({wr1, bus1, en1, a1}), 64'({1'b0, 1'b0, 1'b1, 6'd0}));

        // LOAD on the ROM_LAT=3 / RAM_LAT=2 instance: 9-cycle instruction.
        clear_rom();
        rom[0] = 16'h1805;
        do_reset("reset_e");
        rd_c = -1; cap_c = -1; cap_n = 0; we_c = -1; f_c = -1;
        bus_seen = 1'b0; ra_at_rd = '0; wb_ctl = '1;
        for (int c = 0; c < 20 && f_c < 0; c++) begin
            if (en2 && a2 == 6'd1) begin
                f_c = c;
            end else begin
                if (rd2 && rd_c < 0) begin
                    rd_c = c;
                    ra_at_rd = ra2;
                end
                if (cap2) begin
                    cap_n++;
                    if (cap_c < 0) cap_c = c;
                end
                if (we2 && we_c < 0) begin
                    we_c = c;
                    wb_ctl = {rsel2, wb2, op2};
                end
                if (bus2 || wr2) bus_seen = 1'b1;
                next_cycle();
            end
        end
        check("slow_rd_cycle", 64'(rd_c), 64'(5));
        check("slow_rd_addr", 64'(ra_at_rd), 64'(6'd5));
        check("slow_cap_cycle", 64'(cap_c), 64'(7));
        check("slow_cap_count", 64'(cap_n), 64'(1));
        check("slow_we_cycle", 64'(we_c), 64'(8));
        check("slow_wb_ctl", 64'(wb_ctl), 64'({2'd2, 1'b0, 2'b00}));
        check("slow_next_fetch", 64'(f_c), 64'(9));
        check("slow_ir", 64'(ir2), 64'(16'h1805));
        check("slow_no_write", 64'({bus_seen, hlt2, ill2}), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
